// File: rtl/fpdiv_result_queue.sv
// fpdiv_result_queue: captures divider results on each DONE rising edge,
// classifies the IEEE-754 single-precision quotient and buffers
// {EXCEPTION, class, AbyB} in a DEPTH-entry FIFO. The FIFO drains over a
// show-ahead valid/ready port.
//   CLOCK, RESET        : rising-edge clock, synchronous active-low reset
//   AbyB, DONE, EXCEPTION : divider result, completion flag, exception code
//   OUT_DATA/CLASS/EXC/VALID, OUT_READY : head entry and handshake
//   COUNT, FULL, DROPPED : occupancy, full flag, saturating overflow-loss count
module fpdiv_result_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [31:0]      AbyB,
    input  logic             DONE,
    input  logic [1:0]       EXCEPTION,
    output logic [31:0]      OUT_DATA,
    output logic [2:0]       OUT_CLASS,
    output logic [1:0]       OUT_EXC,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [PTR_W:0]   COUNT,
    output logic             FULL,
    output logic [7:0]       DROPPED
);

    localparam int unsigned ENTRY_W = 37;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;

    // IEEE-754 single-precision class code of a quotient
    function automatic logic [2:0] classify(input logic [31:0] f);
        logic [7:0]  e;
        logic [22:0] m;
        e = f[30:23];
        m = f[22:0];
        if (e == 8'd0) begin
            classify = (m == 23'd0) ? 3'd0 : 3'd1;
        end else if (e == 8'hFF) begin
            if (m == 23'd0)
                classify = 3'd3;
            else if (m[22])
                classify = 3'd4;
            else
                classify = 3'd5;
        end else begin
            classify = 3'd2;
        end
    endfunction

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [7:0]         dropped_q;
    logic               done_q;
    logic [1:0]         state_q;
    logic [1:0]         state_d;

    logic               push_req_c;
    logic               pop_c;
    logic               full_c;
    logic               push_c;
    logic               drop_c;
    logic [ENTRY_W-1:0] entry_c;
    logic [PTR_W-1:0]   head_idx_c;
    logic [CNT_W-1:0]   remain_c;
    logic [ENTRY_W-1:0] head_c;

    // Handshake and capture decode
    always_comb begin
        push_req_c = DONE & ~done_q;
        pop_c      = OUT_VALID & OUT_READY;
        full_c     = (state_q == ST_FULL);
        push_c     = push_req_c & (~full_c | pop_c);
        drop_c     = push_req_c & full_c & ~pop_c;
        entry_c    = {EXCEPTION, classify(AbyB), AbyB};
        // Head for the next cycle: skip past the entry being popped now.
        // Only entries already stored before this edge become visible, which
        // gives a newly captured result one cycle of latency.
        head_idx_c = rd_ptr + PTR_W'(pop_c);
        remain_c   = count_q - CNT_W'(pop_c);
        head_c     = mem[head_idx_c];
    end

    // Occupancy update
    always_comb begin
        count_d = count_q;
        if (push_c && !pop_c)
            count_d = count_q + CNT_W'(1);
        else if (!push_c && pop_c)
            count_d = count_q - CNT_W'(1);
    end

    // Occupancy state machine: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (push_c)
                    state_d = (count_d == CNT_MAX) ? ST_FULL : ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (count_d == CNT_MAX)
                    state_d = ST_FULL;
                else if (count_d == CNT_W'(0))
                    state_d = ST_EMPTY;
            end
            ST_FULL: begin
                if (pop_c && !push_c)
                    state_d = ST_ACTIVE;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Storage array; stale contents are harmless once pointers are reset
    always_ff @(posedge CLOCK) begin
        if (push_c)
            mem[wr_ptr] <= entry_c;
    end

    // Control registers and registered outputs
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            done_q    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            dropped_q <= '0;
            state_q   <= ST_EMPTY;
            FULL      <= 1'b0;
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_CLASS <= '0;
            OUT_EXC   <= '0;
        end else begin
            done_q  <= DONE;
            count_q <= count_d;
            state_q <= state_d;
            FULL    <= (state_d == ST_FULL);
            if (push_c)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (drop_c && (dropped_q != 8'hFF))
                dropped_q <= dropped_q + 8'd1;
            OUT_VALID <= (remain_c != CNT_W'(0));
            // Hold the payload when nothing is presented
            if (remain_c != CNT_W'(0)) begin
                OUT_EXC   <= head_c[36:35];
                OUT_CLASS <= head_c[34:32];
                OUT_DATA  <= head_c[31:0];
            end
        end
    end

    assign COUNT   = count_q;
    assign DROPPED = dropped_q;

endmodule

// File: tb/tb_fpdiv_result_queue.sv
// Testbench for fpdiv_result_queue: directed scenarios plus a random phase,
// checked by a queue-based reference model and a negedge monitor.
module tb_fpdiv_result_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;

    typedef struct packed {
        logic [1:0]  exc;
        logic [2:0]  cls;
        logic [31:0] data;
    } ent_t;

    logic             CLOCK = 1'b0;
    logic             RESET = 1'b0;
    logic [31:0]      AbyB = '0;
    logic             DONE = 1'b0;
    logic [1:0]       EXCEPTION = '0;
    logic [31:0]      OUT_DATA;
    logic [2:0]       OUT_CLASS;
    logic [1:0]       OUT_EXC;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;
    logic [PTR_W:0]   COUNT;
    logic             FULL;
    logic [7:0]       DROPPED;

    fpdiv_result_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .AbyB(AbyB), .DONE(DONE),
        .EXCEPTION(EXCEPTION), .OUT_DATA(OUT_DATA), .OUT_CLASS(OUT_CLASS),
        .OUT_EXC(OUT_EXC), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .COUNT(COUNT), .FULL(FULL), .DROPPED(DROPPED)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    ent_t sb[$];
    int   drops = 0;
    int   old_cnt = 0;
    bit   prev_done = 1'b0;
    bit   pop_pending = 1'b0;
    bit   started = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_class(input logic [31:0] v);
        int unsigned ex;
        int unsigned mant;
        ex   = v[30:23];
        mant = v[22:0];
        if (ex == 255) begin
            if (mant == 0) return 3'd3;
            return v[22] ? 3'd4 : 3'd5;
        end
        if (ex == 0) return (mant == 0) ? 3'd0 : 3'd1;
        return 3'd2;
    endfunction

    // Model: applies pops seen by the monitor, then captures on DONE rise
    always @(posedge CLOCK) begin
        started = 1'b1;
        if (!RESET) begin
            sb.delete();
            drops     = 0;
            prev_done = 1'b0;
            old_cnt   = 0;
        end else begin
            if (pop_pending && sb.size() > 0)
                void'(sb.pop_front());
            old_cnt = sb.size();
            if (DONE && !prev_done) begin
                if (sb.size() < DEPTH)
                    sb.push_back('{exc: EXCEPTION, cls: ref_class(AbyB), data: AbyB});
                else if (drops < 255)
                    drops++;
            end
            prev_done = DONE;
        end
        pop_pending = 1'b0;
    end

    // Monitor: compares presented head and status against the model
    always @(negedge CLOCK) begin
        if (started) begin
            chk("count", 64'(COUNT), 64'(sb.size()));
            chk("full", 64'(FULL), 64'(sb.size() == DEPTH));
            chk("dropped", 64'(DROPPED), 64'(drops));
            chk("valid", 64'(OUT_VALID), 64'(old_cnt != 0));
            if (OUT_VALID) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL head: valid with data 0x%0h but no entry expected at %0t",
                             OUT_DATA, $time);
                end else begin
                    chk("head_data", 64'(OUT_DATA), 64'(sb[0].data));
                    chk("head_class", 64'(OUT_CLASS), 64'(sb[0].cls));
                    chk("head_exc", 64'(OUT_EXC), 64'(sb[0].exc));
                end
                pop_pending = OUT_READY;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic pulse(input logic [31:0] d, input logic [1:0] x, input int hold);
        AbyB = d;
        EXCEPTION = x;
        DONE = 1'b1;
        cyc(hold);
        DONE = 1'b0;
        cyc(1);
    endtask

    task automatic drain(input int budget);
        OUT_READY = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (COUNT == '0 && !OUT_VALID) break;
            cyc(1);
        end
        chk("drain_count", 64'(COUNT), 64'd0);
        chk("drain_valid", 64'(OUT_VALID), 64'd0);
    endtask

    function automatic logic [31:0] rand_float();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 5))
            0: v[30:0] = '0;
            1: begin v[30:23] = 8'h00; v[0] = 1'b1; end
            2: if (v[30:23] == 8'h00 || v[30:23] == 8'hFF) v[30:23] = 8'h80;
            3: begin v[30:23] = 8'hFF; v[22:0] = '0; end
            4: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
            default: begin v[30:23] = 8'hFF; v[22] = 1'b0; v[1] = 1'b1; end
        endcase
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for two cycles
        cyc(2);
        chk("rst_data", 64'(OUT_DATA), 64'd0);
        chk("rst_class", 64'(OUT_CLASS), 64'd0);
        chk("rst_exc", 64'(OUT_EXC), 64'd0);
        RESET = 1'b1;
        cyc(1);

        // DONE held three cycles yields one entry
        pulse(32'h3F800000, 2'b00, 3);
        chk("t1_count", 64'(COUNT), 64'd1);
        chk("t1_data", 64'(OUT_DATA), 64'h3F800000);
        chk("t1_class", 64'(OUT_CLASS), 64'd2);

        // Classification, one cycle after capture
        OUT_READY = 1'b1;
        cyc(2);
        pulse(32'h80000000, 2'b00, 1); chk("t2_zero", 64'(OUT_CLASS), 64'd0);
        pulse(32'h00000001, 2'b00, 1); chk("t2_sub", 64'(OUT_CLASS), 64'd1);
        pulse(32'h7F800000, 2'b01, 1); chk("t2_inf", 64'(OUT_CLASS), 64'd3);
        chk("t2_inf_exc", 64'(OUT_EXC), 64'd1);
        pulse(32'hFFC00000, 2'b10, 1); chk("t2_qnan", 64'(OUT_CLASS), 64'd4);
        pulse(32'h7F800001, 2'b00, 1); chk("t2_snan", 64'(OUT_CLASS), 64'd5);
        drain(20);

        // Overflow: five results into four slots
        OUT_READY = 1'b0;
        for (int i = 1; i <= 5; i++) pulse(32'(i), 2'b00, 1);
        chk("t3_full", 64'(FULL), 64'd1);
        chk("t3_count", 64'(COUNT), 64'd4);
        chk("t3_dropped", 64'(DROPPED), 64'd1);
        drain(20);

        // Full queue: pop and capture in the same cycle
        OUT_READY = 1'b0;
        for (int i = 0; i < 4; i++) pulse(32'h40000000 + 32'(i), 2'b00, 1);
        AbyB = 32'h41200000;
        DONE = 1'b1;
        OUT_READY = 1'b1;
        cyc(1);
        DONE = 1'b0;
        OUT_READY = 1'b0;
        cyc(1);
        chk("t4_count", 64'(COUNT), 64'd4);
        chk("t4_full", 64'(FULL), 64'd1);
        chk("t4_dropped", 64'(DROPPED), 64'd1);

        // Saturation of the drop counter
        for (int i = 0; i < 300; i++) pulse($urandom, 2'(i), 1);
        chk("t5_dropped", 64'(DROPPED), 64'd255);
        chk("t5_count", 64'(COUNT), 64'd4);
        drain(20);

        // Reset mid-operation
        OUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) pulse(32'h3F000000 + 32'(i), 2'b00, 1);
        RESET = 1'b0;
        cyc(1);
        RESET = 1'b1;
        chk("t6_count", 64'(COUNT), 64'd0);
        chk("t6_valid", 64'(OUT_VALID), 64'd0);
        chk("t6_dropped", 64'(DROPPED), 64'd0);
        pulse(32'h40490FDB, 2'b00, 1);
        chk("t6_data", 64'(OUT_DATA), 64'h40490FDB);
        chk("t6_class", 64'(OUT_CLASS), 64'd2);
        drain(20);

        // Random traffic with a stalling consumer
        for (int i = 0; i < 1500; i++) begin
            DONE = ($urandom_range(0, 2) == 0);
            AbyB = rand_float();
            EXCEPTION = 2'($urandom);
            OUT_READY = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        DONE = 1'b0;
        cyc(1);
        drain(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
